// File: rtl/bidir_bridge.sv
// bidir_bridge: half-duplex bridge moving data A->B or B->A with a turnaround gap.
// Ports: clk, rst_n, req_a/req_b, io_a/io_b (tri-state), grant_a/grant_b, dir, xfer_cnt.
module bidir_bridge #(
  parameter int WIDTH    = 8,
  parameter int TURN_CYC = 2,
  parameter int PRIO_A   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  inout  wire [WIDTH-1:0]  io_a,
  inout  wire [WIDTH-1:0]  io_b,
  output logic             grant_a,
  output logic             grant_b,
  output logic [1:0]       dir,
  output logic [15:0]      xfer_cnt
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] A2B  = 2'b01;
  localparam logic [1:0] B2A  = 2'b10;
  localparam logic [1:0] TURN = 2'b11;

  localparam logic [3:0] TURN_LOAD = 4'(TURN_CYC - 1);
  localparam bit         A_WINS    = (PRIO_A != 0);

  logic [1:0]       state;
  logic [1:0]       nxt;
  logic [3:0]       turn_cnt;
  logic [WIDTH-1:0] data_q;
  logic             ra;
  logic             rb;

  // Unknown request levels count as "no request".
  assign ra = (req_a === 1'b1);
  assign rb = (req_b === 1'b1);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (ra && (A_WINS || !rb))
          nxt = A2B;
        else if (rb)
          nxt = B2A;
      end
      A2B:  if (!ra) nxt = TURN;
      B2A:  if (!rb) nxt = TURN;
      default: if (turn_cnt == 4'd0) nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      turn_cnt <= 4'd0;
      data_q   <= '0;
      xfer_cnt <= 16'd0;
    end else begin
      state <= nxt;
      if (state != TURN && nxt == TURN)
        turn_cnt <= TURN_LOAD;
      else if (state == TURN && turn_cnt != 4'd0)
        turn_cnt <= turn_cnt - 4'd1;
      if (nxt == A2B)
        data_q <= io_a;
      else if (nxt == B2A)
        data_q <= io_b;
      if ((state == A2B || state == B2A) && xfer_cnt != 16'hFFFF)
        xfer_cnt <= xfer_cnt + 16'd1;
    end
  end

  assign grant_a = (state == A2B);
  assign grant_b = (state == B2A);
  assign dir     = state;

  // Only the destination side is ever driven; the source stays released.
  assign io_b = (state == A2B) ? data_q : {WIDTH{1'bz}};
  assign io_a = (state == B2A) ? data_q : {WIDTH{1'bz}};

endmodule
